// File: rtl/matmul_index_sequencer.sv
// Loop-control FSM for the i/j/k index registers of the matrix-multiply datapath.
// Issues load/increment strobes plus one MAC strobe per (i,j,k) and one store strobe per (i,j).
module matmul_index_sequencer #(
  parameter int word_size = 16,
  parameter int dim       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step_ready,
  input  logic [word_size-1:0] i_q,
  input  logic [word_size-1:0] j_q,
  input  logic [word_size-1:0] k_q,
  output logic                 i_we,
  output logic                 j_we,
  output logic                 k_we,
  output logic                 i_inc,
  output logic                 j_inc,
  output logic                 k_inc,
  output logic [word_size-1:0] i_data,
  output logic [word_size-1:0] j_data,
  output logic [word_size-1:0] k_data,
  output logic                 mac_en,
  output logic                 store_en,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MAC,
    S_STORE,
    S_DONE
  } state_t;

  localparam logic [word_size-1:0] LAST = word_size'(dim - 1);

  state_t r_state;
  state_t w_next;
  logic   w_i_last;
  logic   w_j_last;
  logic   w_k_last;

  // Loop exits compare the fed-back register values, valid one cycle after a strobe.
  assign w_i_last = (i_q == LAST);
  assign w_j_last = (j_q == LAST);
  assign w_k_last = (k_q == LAST);

  // Registers are only ever loaded with zero.
  assign i_data = '0;
  assign j_data = '0;
  assign k_data = '0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    i_we     = 1'b0;
    j_we     = 1'b0;
    k_we     = 1'b0;
    i_inc    = 1'b0;
    j_inc    = 1'b0;
    k_inc    = 1'b0;
    mac_en   = 1'b0;
    store_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_INIT;
      end
      S_INIT: begin
        busy   = 1'b1;
        i_we   = 1'b1;
        j_we   = 1'b1;
        k_we   = 1'b1;
        w_next = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (step_ready) begin
          mac_en = 1'b1;
          if (!w_k_last) k_inc  = 1'b1;
          else           w_next = S_STORE;
        end
      end
      S_STORE: begin
        busy = 1'b1;
        if (step_ready) begin
          store_en = 1'b1;
          k_we     = 1'b1;
          if (!w_j_last) begin
            j_inc  = 1'b1;
            w_next = S_MAC;
          end else begin
            // Row finished: rewind j and either advance i or finish.
            j_we = 1'b1;
            if (!w_i_last) begin
              i_inc  = 1'b1;
              w_next = S_MAC;
            end else begin
              w_next = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
